// File: rtl/rv_pkg.sv
// Shared RISC-V decode constants for the ID stage.
package rv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/id_decode.sv
// Combinational decode: register-read enables, writeback enable and all
// immediate / pc-relative operand values that do not come from the register file.
module id_decode
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     i_is,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_legal,
    output logic            o_re1,
    output logic            o_re2,
    output logic            o_we,
    output logic [XLEN-1:0] o_imm1,
    output logic [XLEN-1:0] o_imm2,
    output logic [XLEN-1:0] o_immn,
    output logic [XLEN-1:0] o_npc
);

    logic [XLEN-1:0] w_immI, w_immS, w_immB, w_immU, w_immJ, w_shamt, w_pc4;
    logic            w_isShift;
    logic            w_weOp;

    assign w_immI    = XLEN'($signed(i_is[31:20]));
    assign w_immS    = XLEN'($signed({i_is[31:25], i_is[11:7]}));
    assign w_immB    = XLEN'($signed({i_is[31], i_is[7], i_is[30:25], i_is[11:8], 1'b0}));
    assign w_immU    = XLEN'($signed({i_is[31:12], 12'b0}));
    assign w_immJ    = XLEN'($signed({i_is[31], i_is[19:12], i_is[20], i_is[30:21], 1'b0}));
    // RV64 shift amounts borrow bit 25 from the funct7 field
    assign w_shamt   = (XLEN == 64) ? XLEN'(i_is[25:20]) : XLEN'(i_is[24:20]);
    assign w_isShift = (i_is[14:12] == F3_SLL) || (i_is[14:12] == F3_SRX);
    assign w_pc4     = i_pc + XLEN'(4);

    always_comb begin
        o_legal = 1'b0;
        o_re1   = 1'b0;
        o_re2   = 1'b0;
        w_weOp  = 1'b0;
        o_imm1  = '0;
        o_imm2  = '0;
        o_immn  = '0;
        o_npc   = '0;
        case (i_is[6:0])
            LUI: begin
                o_legal = 1'b1; w_weOp = 1'b1;
                o_imm1  = w_immU;
            end
            AUIPC: begin
                o_legal = 1'b1; w_weOp = 1'b1;
                o_imm1  = w_immU;
                o_imm2  = i_pc;
            end
            JAL: begin
                o_legal = 1'b1; w_weOp = 1'b1;
                o_imm1  = w_pc4;
                o_npc   = i_pc + w_immJ;
            end
            JALR: begin
                o_legal = 1'b1; o_re1 = 1'b1; w_weOp = 1'b1;
                o_imm2  = w_pc4;
                o_npc   = w_immI;
            end
            BRANCH: begin
                o_legal = 1'b1; o_re1 = 1'b1; o_re2 = 1'b1;
                o_npc   = i_pc + w_immB;
            end
            LOAD: begin
                o_legal = 1'b1; o_re1 = 1'b1;
                o_imm2  = w_immI;
            end
            STORE: begin
                o_legal = 1'b1; o_re1 = 1'b1; o_re2 = 1'b1;
                o_immn  = w_immS;
            end
            OP_IMM: begin
                o_legal = 1'b1; o_re1 = 1'b1; w_weOp = 1'b1;
                o_imm2  = w_isShift ? w_shamt : w_immI;
            end
            OP: begin
                o_legal = 1'b1; o_re1 = 1'b1; o_re2 = 1'b1; w_weOp = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_we = w_weOp && (i_is[11:7] != 5'd0);

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: operand forwarding, load-use stall detection and
// the ID/EX pipeline register with fetch-side ready/valid handshake.
module id_stage
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NFWD = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_valid,
    output logic                 if_ready,
    input  logic [XLEN-1:0]      if_pc,
    input  logic [31:0]          if_is,
    output logic [4:0]           ra1,
    output logic [4:0]           ra2,
    output logic                 re1,
    output logic                 re2,
    input  logic [XLEN-1:0]      rn1,
    input  logic [XLEN-1:0]      rn2,
    input  logic [5*NFWD-1:0]    fwd_wa,
    input  logic [XLEN*NFWD-1:0] fwd_wn,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic                 ex_ld,
    input  logic [4:0]           ex_ld_wa,
    input  logic                 flush,
    input  logic                 ex_ready,
    output logic                 id_valid,
    output logic [6:0]           t,
    output logic [2:0]           st,
    output logic                 sst,
    output logic [XLEN-1:0]      out1,
    output logic [XLEN-1:0]      out2,
    output logic [XLEN-1:0]      outn,
    output logic [4:0]           wa,
    output logic                 we,
    output logic [XLEN-1:0]      npc
);

    // Youngest matching source wins, so scan oldest-first and let later hits override
    function automatic logic [XLEN-1:0] fwdSel(
        input logic [4:0]           ra,
        input logic [XLEN-1:0]      rn,
        input logic [5*NFWD-1:0]    fwa,
        input logic [XLEN*NFWD-1:0] fwn,
        input logic [NFWD-1:0]      fwe
    );
        fwdSel = rn;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwe[i] && (fwa[5*i +: 5] == ra)) fwdSel = fwn[XLEN*i +: XLEN];
        end
        if (ra == 5'd0) fwdSel = '0;
    endfunction

    logic            w_legal, w_we;
    logic [XLEN-1:0] w_imm1, w_imm2, w_immn, w_npc;
    logic [XLEN-1:0] w_rs1, w_rs2;
    logic            w_hazard, w_accept, w_advance;

    logic            r_valid, r_sst, r_we;
    logic [6:0]      r_t;
    logic [2:0]      r_st;
    logic [4:0]      r_wa;
    logic [XLEN-1:0] r_out1, r_out2, r_outn, r_npc;

    id_decode #(.XLEN(XLEN)) u_decode (
        .i_is    (if_is),
        .i_pc    (if_pc),
        .o_legal (w_legal),
        .o_re1   (re1),
        .o_re2   (re2),
        .o_we    (w_we),
        .o_imm1  (w_imm1),
        .o_imm2  (w_imm2),
        .o_immn  (w_immn),
        .o_npc   (w_npc)
    );

    assign ra1   = if_is[19:15];
    assign ra2   = if_is[24:20];
    assign w_rs1 = fwdSel(ra1, rn1, fwd_wa, fwd_wn, fwd_we);
    assign w_rs2 = fwdSel(ra2, rn2, fwd_wa, fwd_wn, fwd_we);

    assign w_hazard  = ex_ld && (ex_ld_wa != 5'd0) &&
                       ((re1 && (ra1 == ex_ld_wa)) || (re2 && (ra2 == ex_ld_wa)));
    assign w_advance = !r_valid || ex_ready;
    assign if_ready  = rst_n && w_advance && !w_hazard && !flush;
    assign w_accept  = if_valid && if_ready;

    // Illegal or zero words are consumed but land as a bubble with no writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_t     <= '0;
            r_st    <= '0;
            r_sst   <= 1'b0;
            r_out1  <= '0;
            r_out2  <= '0;
            r_outn  <= '0;
            r_wa    <= '0;
            r_we    <= 1'b0;
            r_npc   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
        end else if (w_advance) begin
            r_valid <= w_accept && w_legal;
            r_we    <= w_accept && w_legal && w_we;
            r_t     <= if_is[6:0];
            r_st    <= if_is[14:12];
            r_sst   <= if_is[30];
            r_wa    <= if_is[11:7];
            r_out1  <= re1 ? w_rs1 : w_imm1;
            r_out2  <= re2 ? w_rs2 : w_imm2;
            r_outn  <= w_immn;
            r_npc   <= w_npc;
        end
    end

    assign id_valid = r_valid;
    assign t        = r_t;
    assign st       = r_st;
    assign sst      = r_sst;
    assign out1     = r_out1;
    assign out2     = r_out2;
    assign outn     = r_outn;
    assign wa       = r_wa;
    assign we       = r_we;
    assign npc      = r_npc;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter NFWD, default 2, meaning forwarding sources; index 0 youngest (EX), ascending older (MEM, WB...).
REQ-003 SHALL have port clk  in  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports if_valid in 1, if_ready out 1, if_pc in XLEN, if_is in 32: fetch handshake, instruction address, instruction word.
REQ-006 SHALL have ports ra1, ra2 out 5, re1, re2 out 1, rn1, rn2 in XLEN: combinational register-file read for the instruction on if_is.
REQ-007 SHALL have ports fwd_wa in 5*NFWD, fwd_wn in XLEN*NFWD, fwd_we in NFWD: packed forwarding buses.
REQ-008 SHALL have ports ex_ld in 1, ex_ld_wa in 5: EX holds a load targeting ex_ld_wa.
REQ-009 SHALL have ports flush in 1 (redirect, kill ID), ex_ready in 1 (EX accepts this cycle).
REQ-010 SHALL have registered outputs id_valid 1, t 7, st 3, sst 1, out1 XLEN, out2 XLEN, outn XLEN, wa 5, we 1, npc XLEN.

Function
REQ-011 Accept = if_valid && if_ready; accepted instruction's decode SHALL appear on outputs at the next edge (latency 1).
REQ-012 if_ready SHALL be (!id_valid || ex_ready) && !hazard && !flush.
REQ-013 hazard SHALL be ex_ld && ex_ld_wa!=0 && ((re1 && ra1==ex_ld_wa) || (re2 && ra2==ex_ld_wa)).
REQ-014 On hazard with ex_ready=1, id_valid SHALL go 0 next cycle (bubble); if_is held by fetch is re-decoded later.
REQ-015 When id_valid=1 and ex_ready=0 and no flush, all outputs SHALL hold unchanged.
REQ-016 flush SHALL force id_valid=0 next cycle, overriding accept and hold.
REQ-017 if_is==0 or unknown opcode SHALL be accepted as a bubble: id_valid=0, we=0.
REQ-018 Operand source, per port: register x0 SHALL yield 0; else lowest index i with fwd_we[i] && fwd_wa[i]==ra yields fwd_wn[i]; else rn.
REQ-019 re1/re2/we by opcode: LUI,AUIPC,JAL we only; OP re1,re2,we; JALR,OP-IMM re1,we; BRANCH,STORE re1,re2; LOAD re1 only.
REQ-020 out1: rs1 value if re1, else LUI U-imm, AUIPC U-imm, JAL pc+4.
REQ-021 out2: rs2 value if re2; AUIPC if_pc; JALR pc+4; OP-IMM/LOAD I-imm sign-extended to XLEN.
REQ-022 OP-IMM shift immediate SHALL be is[24:20] for XLEN=32, is[25:20] for XLEN=64, zero-extended.
REQ-023 outn SHALL be S-imm for STORE, else 0.
REQ-024 npc SHALL be if_pc+B-imm (BRANCH), if_pc+J-imm (JAL), I-imm (JALR, EX adds rs1), else 0; arithmetic modulo 2^XLEN.
REQ-025 t, st, sst, wa SHALL be is[6:0], is[14:12], is[30], is[11:7]; wa=0 forces we=0.

Reset
REQ-026 rst_n low SHALL asynchronously clear all registered outputs to 0, including id_valid.
REQ-027 if_ready SHALL be 0 while rst_n low; first accept possible on first edge after deassertion.
REQ-028 Reset mid-stall SHALL discard held instruction; no output pulse after release.

Structure
REQ-029 Opcode constants (LUI, AUIPC, OP, JAL, JALR, BRANCH, STORE, OP_IMM, LOAD) and XLEN default SHALL live in shared package rv_pkg.
REQ-030 Combinational decode/immediate generation SHALL be sub-module id_decode; forwarding mux and pipeline register remain in id_stage.
REQ-031 Forwarding mux SHALL be a loop over NFWD, no hard-coded source count.

Verification
REQ-032 ADDI x5,x0,7 (0x00700293) at pc 0x100, ex_ready=1 -> next cycle id_valid=1, out1=0, out2=7, wa=5, we=1.
REQ-033 ADD x3,x1,x2 with fwd0=(1,0x11,we) and fwd1=(1,0x22,we), rn2=0x5 -> out1=0x11, out2=0x5.
REQ-034 ex_ld=1, ex_ld_wa=1, if_is ADD x3,x1,x2 -> if_ready=0, id_valid=0 next cycle; drop ex_ld -> accepted, id_valid=1.
REQ-035 JAL x1,+8 at pc 0x200 -> npc=0x208, out1=0x204, we=1; same with flush asserted -> id_valid=0.
REQ-036 id_valid=1, ex_ready=0 for 3 cycles with new if_is -> outputs unchanged, if_ready=0; rst_n low mid-hold -> id_valid=0 immediately.
REQ-037 NFWD=3, XLEN=64, SLLI x4,x4,33 -> out2=33, forwarding from index 2 when 0,1 inactive.
